// File: rtl/bcd_seven_seg_display_if.sv
// Display bus between the calculator datapath and the display driver.
// The datapath (master) supplies the magnitude and sign. The driver (slave)
// returns the BCD image and the anode/cathode pin levels.
interface bcd_seven_seg_display_if;
    logic [31:0] value;
    logic        is_negative;
    logic [39:0] bcd;
    logic [7:0]  AN;
    logic [7:0]  out;

    modport master (
        output value,
        output is_negative,
        input  bcd,
        input  AN,
        input  out
    );

    modport slave (
        input  value,
        input  is_negative,
        output bcd,
        output AN,
        output out
    );
endinterface

// File: rtl/bcd_seven_seg_display.sv
// Eight-digit multiplexed common-anode seven-segment driver.
// It contains a 100 MHz to 5 MHz divider, a combinational 32-bit to 10-digit
// BCD converter, a hex segment decoder, and a digit scanner. The scanner
// forces a minus sign onto digit 7.
// Optional feature macro: LEADING_ZERO_BLANK_EN. When it is defined, leading
// zero digits 1..7 are blanked.

// Active-low segment decoder; bit order {dp,g,f,e,d,c,b,a}, dp always off.
module hex_to_seg (
    input  logic [3:0] nib,
    output logic [7:0] seg
);
    // Map one nibble to its cathode pattern.
    always_comb begin
        seg = 8'hFF;
        case (nib)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            4'hF: seg = 8'h8E;
            default: seg = 8'hFF;
        endcase
    end
endmodule

module bcd_seven_seg_display (
    input  logic                         CLK100MHZ,
    input  logic                         RST,
    output logic                         CLK5MHZ,
    bcd_seven_seg_display_if.slave       bus
);
    logic [3:0]  div_q, div_d;
    logic        clk5_q, clk5_d;
    logic [19:0] refresh_q, refresh_d;

    logic [39:0] bcd_w;
    logic [3:0]  nib_arr [8];
    logic [2:0]  digit_sel;
    logic [3:0]  nib_sel;
    logic [7:0]  seg_w;
    logic        blank_w;
    logic [7:0]  an_w;
    logic [7:0]  out_w;

    // Next-state for the divide-by-10 phase counter, the 5 MHz toggle and the scan counter.
    always_comb begin
        div_d     = (div_q == 4'd9) ? 4'd0 : div_q + 4'd1;
        clk5_d    = (div_q == 4'd9) ? ~clk5_q : clk5_q;
        refresh_d = refresh_q + 20'd1;
    end

    // State registers; reset clears every phase so nothing carries across.
    always_ff @(posedge CLK100MHZ) begin
        if (RST) begin
            div_q     <= 4'd0;
            clk5_q    <= 1'b0;
            refresh_q <= 20'd0;
        end else begin
            div_q     <= div_d;
            clk5_q    <= clk5_d;
            refresh_q <= refresh_d;
        end
    end

    assign CLK5MHZ = clk5_q;

    // Double-dabble: add 3 to any digit >= 5, then shift in the next bit.
    // The top digit never exceeds 4 for a 32-bit input, so 40 bits suffice.
    always_comb begin
        bcd_w = '0;
        for (int i = 31; i >= 0; i--) begin
            for (int j = 0; j < 10; j++) begin
                if (bcd_w[4*j +: 4] > 4'd4) begin
                    bcd_w[4*j +: 4] = bcd_w[4*j +: 4] + 4'd3;
                end
            end
            bcd_w = {bcd_w[38:0], bus.value[i]};
        end
    end

    // Split the displayed low eight digits into an indexable array.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            nib_arr[k] = bcd_w[4*k +: 4];
        end
    end

    assign digit_sel = refresh_q[19:17];
    assign nib_sel   = nib_arr[digit_sel];

    hex_to_seg u_dec (
        .nib (nib_sel),
        .seg (seg_w)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic [7:0] zero_from;

    // zero_from[k] is set when digits k..7 are all zero; digit 0 is never blanked.
    always_comb begin
        zero_from    = '0;
        zero_from[7] = (nib_arr[7] == 4'd0);
        for (int k = 6; k >= 0; k--) begin
            zero_from[k] = zero_from[k+1] && (nib_arr[k] == 4'd0);
        end
        blank_w = (digit_sel != 3'd0) && zero_from[digit_sel];
    end
`else
    assign blank_w = 1'b0;
`endif

    // Anode select and cathode pattern; the minus sign wins over blanking and the numeral.
    always_comb begin
        an_w  = ~(8'b0000_0001 << digit_sel);
        out_w = seg_w;
        if ((digit_sel == 3'd7) && bus.is_negative) begin
            out_w = 8'hBF;
        end else if (blank_w) begin
            out_w = 8'hFF;
        end
    end

    assign bus.bcd = bcd_w;
    assign bus.AN  = an_w;
    assign bus.out = out_w;
endmodule

// File: tb/tb_bcd_seven_seg_display.sv
module tb_bcd_seven_seg_display;
    logic CLK100MHZ = 1'b0;
    logic RST;
    logic CLK5MHZ;
    bcd_seven_seg_display_if bus_i ();

    bcd_seven_seg_display dut (
        .CLK100MHZ (CLK100MHZ),
        .RST       (RST),
        .CLK5MHZ   (CLK5MHZ),
        .bus       (bus_i.slave)
    );

    logic [3:0] sweep_nib;
    logic [7:0] sweep_seg;
    hex_to_seg u_sweep (
        .nib (sweep_nib),
        .seg (sweep_seg)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    int n_checks = 0;
    int n_fail   = 0;
    logic [19:0] force_val;

    logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
`ifdef LEADING_ZERO_BLANK_EN
    logic [7:0] exp_1234 [8] = '{8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    logic [7:0] exp_42   [8] = '{8'hA4, 8'h99, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    logic [7:0] exp_zero_d3 = 8'hFF;
`else
    logic [7:0] exp_1234 [8] = '{8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
    logic [7:0] exp_42   [8] = '{8'hA4, 8'h99, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
    logic [7:0] exp_zero_d3 = 8'hC0;
`endif
    logic [7:0] exp_max [8] = '{8'h92, 8'h90, 8'hA4, 8'hF8, 8'h82, 8'h90, 8'h99, 8'h90};

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pin the scan counter onto digit d and check the anodes and cathodes.
    task automatic check_digit(input string tag, input int d, input logic [7:0] exp_out);
        logic [7:0] exp_an;
        force_val = {d[2:0], 17'd0};
        force dut.refresh_q = force_val;
        #1;
        exp_an = ~(8'b0000_0001 << d);
        check($sformatf("%s_d%0d_an", tag, d), {32'd0, bus_i.AN}, {32'd0, exp_an});
        check($sformatf("%s_d%0d_out", tag, d), {32'd0, bus_i.out}, {32'd0, exp_out});
    endtask

    initial begin
        RST               = 1'b1;
        bus_i.value       = 32'd0;
        bus_i.is_negative = 1'b0;
        sweep_nib         = 4'd0;

        // Reset state
        repeat (2) @(posedge CLK100MHZ);
        #1;
        check("rst_an", {32'd0, bus_i.AN}, 40'hFE);
        check("rst_out", {32'd0, bus_i.out}, 40'hC0);
        check("rst_clk5", {39'd0, CLK5MHZ}, 40'd0);

        // Divider phase after release: rises on edge 10, falls on edge 20
        @(negedge CLK100MHZ);
        RST = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge CLK100MHZ);
            #1;
            check($sformatf("clk5_e%0d", i), {39'd0, CLK5MHZ}, {39'd0, (i >= 10 && i < 20)});
        end
        check("scan_still_d0", {32'd0, bus_i.AN}, 40'hFE);

        // Reset mid-operation restarts the divide phase
        repeat (7) @(posedge CLK100MHZ);
        @(negedge CLK100MHZ);
        RST = 1'b1;
        @(posedge CLK100MHZ);
        #1;
        check("midrst_clk5", {39'd0, CLK5MHZ}, 40'd0);
        check("midrst_an", {32'd0, bus_i.AN}, 40'hFE);
        @(negedge CLK100MHZ);
        RST = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge CLK100MHZ);
            #1;
            if (i >= 9)
                check($sformatf("midrst_clk5_e%0d", i), {39'd0, CLK5MHZ}, {39'd0, (i == 10)});
        end

        // BCD conversion
        bus_i.value = 32'd1234;       #1; check("bcd_1234", bus_i.bcd, 40'h0000001234);
        bus_i.value = 32'd0;          #1; check("bcd_0", bus_i.bcd, 40'h0000000000);
        bus_i.value = 32'd10;         #1; check("bcd_10", bus_i.bcd, 40'h0000000010);
        bus_i.value = 32'd99999999;   #1; check("bcd_99999999", bus_i.bcd, 40'h0099999999);
        bus_i.value = 32'd100000000;  #1; check("bcd_1e8", bus_i.bcd, 40'h0100000000);
        bus_i.value = 32'hFFFFFFFF;   #1; check("bcd_max", bus_i.bcd, 40'h4294967295);

        // Maximum value scan
        for (int d = 0; d < 8; d++) check_digit("max", d, exp_max[d]);

        // Small value scan
        bus_i.value = 32'd1234;
        for (int d = 0; d < 8; d++) check_digit("v1234", d, exp_1234[d]);

        // Value 42 scan
        bus_i.value = 32'd42;
        for (int d = 0; d < 8; d++) check_digit("v42", d, exp_42[d]);

        // Sign override
        bus_i.value = 32'd5;
        bus_i.is_negative = 1'b1;
        check_digit("neg5", 7, 8'hBF);
        check_digit("neg5", 0, 8'h92);
        bus_i.value = 32'd0;
        check_digit("neg0", 7, 8'hBF);
        check_digit("neg0", 3, exp_zero_d3);
        check_digit("neg0", 0, 8'hC0);
        bus_i.is_negative = 1'b0;
        check_digit("pos0", 7, exp_zero_d3);

        // A sign change reaches the cathodes without a clock edge
        bus_i.is_negative = 1'b1;
        #1;
        check("neg_comb", {32'd0, bus_i.out}, 40'hBF);
        bus_i.is_negative = 1'b0;

        // Decoder sweep on digit 0: numerals through the full path, A..F on the decoder
        for (int k = 0; k < 10; k++) begin
            bus_i.value = k;
            check_digit($sformatf("dec%0d", k), 0, seg_tab[k]);
        end
        for (int k = 10; k < 16; k++) begin
            sweep_nib = k[3:0];
            #1;
            check($sformatf("dec%0d", k), {32'd0, sweep_seg}, {32'd0, seg_tab[k]});
        end

        release dut.refresh_q;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
